// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU operation arbiter: opcodes, FSM states, default width.
package fpu_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_op_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves past the granted requester on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant
);

  logic ptr;

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) grant = ptr;
    else if (valid[1]) grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (accept) ptr <= ~grant;
  end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Shares one FPU datapath between two requesters: grant, hold operands, capture, respond.
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | operands held on fpu_*, hold counter running down
// RESP  | result presented on rsp_*, waiting for rsp_ready
module fpu_op_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       fpu_op,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_dz,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_dz,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_t     state, state_nx;
  logic [3:0] hold_cnt;
  logic       grant;
  logic       accept;
  logic       capture;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        // ready is withheld during reset so nothing is accepted while clearing
        if (|req_valid && !rst) begin
          req_ready[grant] = 1'b1;
          state_nx         = EXEC;
        end
      end
      EXEC:    if (hold_cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = |(req_valid & req_ready);
  assign capture   = (state == EXEC) && (hold_cnt == 4'd0);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 4'd0;
      fpu_op   <= 2'b00;
      fpu_a    <= '0;
      fpu_b    <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_dz   <= 1'b0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        fpu_op   <= grant ? req_op1 : req_op0;
        fpu_a    <= grant ? req_a1 : req_a0;
        fpu_b    <= grant ? req_b1 : req_b0;
        rsp_id   <= grant;
        hold_cnt <= 4'(LATENCY - 1);
      end else if (state == EXEC && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (capture) begin
        // the dz flag only has meaning for divide; other ops pass the result through
        if (fpu_op == OP_DIV && fpu_dz) begin
          rsp_data <= '0;
          rsp_dz   <= 1'b1;
        end else begin
          rsp_data <= fpu_result;
          rsp_dz   <= 1'b0;
        end
      end
      if (state == RESP && rsp_ready) ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// Directed bench for fpu_op_arbiter: vector table plus contention, back-pressure, reset and wrap sequences.
module tb_fpu_op_arbiter;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op0, req_op1;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    fpu_op;
  logic [W-1:0]  fpu_a, fpu_b, fpu_result;
  logic          fpu_dz;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;
  logic [W-1:0]  rsp_data;
  logic [CW-1:0] ops_done;

  logic          dp_override;
  logic [W-1:0]  dp_result;
  logic          dp_dz;
  logic [CW-1:0] exp_ops;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // stand-in datapath: a forced value for table vectors, otherwise a ^ b
  assign fpu_result = dp_override ? dp_result : (fpu_a ^ fpu_b);
  assign fpu_dz     = dp_dz;

  fpu_op_arbiter #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_op1    (req_op1),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .fpu_dz     (fpu_dz),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_dz     (rsp_dz),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz_in;
    logic [31:0] exp_data;
    logic        exp_dz;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = '0;
  endtask

  task automatic run_op(input int i);
    int lat;
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    dp_override = 1'b1;
    dp_result   = v.res;
    dp_dz       = v.dz_in;
    rsp_ready   = 1'b1;
    if (v.id) begin
      req_op1 = v.op; req_a1 = v.a; req_b1 = v.b; req_valid = 2'b10;
    end else begin
      req_op0 = v.op; req_a0 = v.a; req_b0 = v.b; req_valid = 2'b01;
    end
    #1 chk($sformatf("v%0d_ready", i), {30'd0, req_ready}, v.id ? 32'd2 : 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk($sformatf("v%0d_fpu_op", i), {30'd0, fpu_op}, {30'd0, v.op});
    chk($sformatf("v%0d_fpu_a", i), fpu_a, v.a);
    chk($sformatf("v%0d_fpu_b", i), fpu_b, v.b);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), lat, LAT + 1);
    chk($sformatf("v%0d_rsp_id", i), {31'd0, rsp_id}, {31'd0, v.id});
    chk($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
    chk($sformatf("v%0d_rsp_dz", i), {31'd0, rsp_dz}, {31'd0, v.exp_dz});
    chk($sformatf("v%0d_ops_before", i), {24'd0, ops_done}, {24'd0, exp_ops});
    @(negedge clk);
    exp_ops = exp_ops + 1'b1;
    chk($sformatf("v%0d_ops_after", i), {24'd0, ops_done}, {24'd0, exp_ops});
    chk($sformatf("v%0d_rsp_clear", i), {31'd0, rsp_valid}, 32'd0);
    dp_override = 1'b0;
    dp_dz       = 1'b0;
  endtask

  initial begin
    int gid [4];
    int gcyc[4];
    int rid [4];
    logic [31:0] rdat[4];
    int ng, nr, n, seen;
    logic [W-1:0] held;

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_op0 = 2'b00; req_a0 = '0; req_b0 = '0;
    req_op1 = 2'b00; req_a1 = '0; req_b1 = '0;
    dp_override = 1'b0; dp_result = '0; dp_dz = 1'b0; exp_ops = '0;

    vecs[0] = '{1'b0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{1'b1, 2'b10, 32'h40A00000, 32'h00000000, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 1'b0};
    vecs[4] = '{1'b0, 2'b11, 32'h40800000, 32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 32'hC0000000, 32'h40000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0};

    // reset state, with both requesters asserting valid
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops_done", {24'd0, ops_done}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(i);

    // contention: both valid continuously, expect alternating grants every LAT+2 cycles
    do_reset();
    req_op0 = 2'b00; req_a0 = 32'h11110000; req_b0 = 32'h0000FFFF;
    req_op1 = 2'b10; req_a1 = 32'hAAAA0000; req_b1 = 32'h00005555;
    rsp_ready = 1'b1; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin gid[k] = -1; gcyc[k] = -1; rid[k] = -1; rdat[k] = 'x; end
    ng = 0; nr = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin
        gid[ng] = int'(req_ready[1]); gcyc[ng] = c; ng++;
      end
      if (rsp_valid && nr < 4) begin
        rid[nr] = int'(rsp_id); rdat[nr] = rsp_data; nr++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), gid[k], k % 2);
      chk($sformatf("cont_rsp_id%0d", k), rid[k], k % 2);
      chk($sformatf("cont_rsp_data%0d", k), rdat[k], (k % 2) ? 32'hAAAA5555 : 32'h1111FFFF);
      if (k > 0) chk($sformatf("cont_gap%0d", k), gcyc[k] - gcyc[k-1], LAT + 2);
    end

    // back-pressure: response held for 10 cycles while the other requester waits
    do_reset();
    req_op0 = 2'b01; req_a0 = 32'h0F0F0000; req_b0 = 32'h000000F0;
    req_op1 = 2'b00; req_a1 = 32'h55550000; req_b1 = 32'h00000001;
    rsp_ready = 1'b0; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b11;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    held = rsp_data;
    chk("bp_rsp_data", held, 32'h0F0F00F0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 2'b00 || ops_done !== 8'd0)
        chk($sformatf("bp_hold%0d", c), {rsp_valid, req_ready, ops_done, rsp_data[20:0]}, {1'b1, 2'b00, 8'd0, held[20:0]});
      else
        total++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ops_after", {24'd0, ops_done}, 32'd1);
    chk("bp_rsp_clear", {31'd0, rsp_valid}, 32'd0);
    #1 chk("bp_next_grant", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;

    // reset during EXEC abandons the operation and restores the pointer
    do_reset();
    req_op0 = 2'b10; req_a0 = 32'hDEAD0000; req_b0 = 32'h0000BEEF;
    rsp_ready = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    chk("rmid_accepted", fpu_a, 32'hDEAD0000);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("rmid_fpu_a", fpu_a, 32'd0);
    chk("rmid_fpu_b", fpu_b, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_rsp", {29'd0, rsp_valid, rsp_id, rsp_dz}, 32'd0);
    chk("rmid_ops", {24'd0, ops_done}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rmid_no_rsp", seen, 0);
    req_valid = 2'b11;
    #1 chk("rmid_first_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end

    // counter wrap: run to all-ones, then one more operation
    do_reset();
    rsp_ready = 1'b1; req_op0 = 2'b00; req_a0 = 32'h1; req_b0 = 32'h2;
    req_valid = 2'b01;
    n = 0;
    while (ops_done != {CW{1'b1}} && n < 2000) begin @(negedge clk); n++; end
    req_valid = 2'b00;
    chk("wrap_full", {24'd0, ops_done}, 32'h000000FF);
    exp_ops = {CW{1'b1}};
    run_op(0);
    chk("wrap_zero", {24'd0, ops_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
